// File: rtl/fault_scan_seq.sv
// rtl/fault_scan_seq.sv - check-scan sequencer for the fault_pro datapath
// Steps the check selector, captures results after settling and compares them to golden vectors.
module fault_scan_seq #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_CHECKS    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  operand,
  input  logic [19:0] exp_res,
  output logic [7:0]  dp_r0,
  output logic [1:0]  dp_check,
  input  logic [2:0]  dp_out,
  input  logic [1:0]  dp_out1,
  output logic        busy,
  output logic        done,
  output logic [3:0]  fail_mask,
  output logic        fault,
  input  logic [1:0]  rd_idx,
  output logic [4:0]  rd_data
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, DONE} state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [1:0] LAST_IDX = 2'(NUM_CHECKS - 1);

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] settle_cnt;
  logic [4:0]    result [4];
  logic [4:0]    captured;
  logic [4:0]    expected;
  logic          mismatch;
  logic [3:0]    mask_next;

  assign captured = {dp_out, dp_out1};

  always_comb begin
    expected = 5'd0;
    for (int i = 0; i < 4; i++) begin
      if (idx == 2'(i)) expected = exp_res[5*i +: 5];
    end
  end

  assign mismatch  = (captured != expected);
  assign mask_next = fail_mask | ({3'b000, mismatch} << idx);
  assign rd_data   = result[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= '0;
      dp_r0      <= 8'd0;
      dp_check   <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail_mask  <= 4'd0;
      fault      <= 1'b0;
      for (int i = 0; i < 4; i++) result[i] <= 5'd0;
    end else if (abort && state != IDLE) begin
      // Abort wins over every in-flight transition; captured results are kept for readback.
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= '0;
      dp_check   <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail_mask  <= 4'd0;
      fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            dp_r0     <= operand;
            idx       <= 2'd0;
            dp_check  <= 2'd0;
            fail_mask <= 4'd0;
            fault     <= 1'b0;
            busy      <= 1'b1;
            for (int i = 0; i < 4; i++) result[i] <= 5'd0;
            state     <= APPLY;
          end
        end
        APPLY: begin
          settle_cnt <= '0;
          if (SETTLE_CYCLES > 0) state <= SETTLE;
          else                   state <= CAPTURE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
          else                           settle_cnt <= settle_cnt + 1'b1;
        end
        CAPTURE: begin
          result[idx] <= captured;
          fail_mask   <= mask_next;
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            fault <= |mask_next;
            state <= DONE;
          end else begin
            idx      <= idx + 2'd1;
            dp_check <= idx + 2'd1;
            state    <= APPLY;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_scan_seq.sv
// tb/tb_fault_scan_seq.sv - directed bench for fault_scan_seq (default and minimal builds)
module tb_fault_scan_seq;

  logic        clk = 1'b0;
  logic        reset, start, start2, abort;
  logic [7:0]  operand;
  logic [19:0] exp_res;
  logic [1:0]  rd_idx;
  logic [7:0]  dp_r0, dp_r0_2;
  logic [1:0]  dp_check, dp_check_2;
  logic [2:0]  dp_out, dp_out_2;
  logic [1:0]  dp_out1, dp_out1_2;
  logic        busy, done, fault, busy2, done2, fault2;
  logic [3:0]  fail_mask, fail_mask2;
  logic [4:0]  rd_data, rd_data2;
  logic [1:0]  last_check = 2'd0;
  int          age = 15;
  int          checks = 0;
  int          fails = 0;

  localparam logic [19:0] EXP_GOOD = {5'h1A, 5'h04, 5'h0D, 5'h15};
  localparam logic [19:0] EXP_BAD2 = {5'h1A, 5'h1F, 5'h0D, 5'h15};
  localparam logic [19:0] EXP_BAD0 = {5'h1A, 5'h04, 5'h0D, 5'h00};

  always #5 clk = ~clk;

  function automatic logic [4:0] dp_model(input logic [1:0] c);
    case (c)
      2'd0:    return 5'h15;
      2'd1:    return 5'h0D;
      2'd2:    return 5'h04;
      default: return 5'h1A;
    endcase
  endfunction

  // Datapath stand-in: results are only correct once the selector has been stable for 3 cycles.
  always @(negedge clk) begin
    if (dp_check !== last_check) begin
      age = 0;
      last_check = dp_check;
    end else if (age < 15) begin
      age = age + 1;
    end
  end

  assign {dp_out, dp_out1}     = (age >= 3) ? dp_model(dp_check) : ~dp_model(dp_check);
  assign {dp_out_2, dp_out1_2} = dp_model(dp_check_2);

  fault_scan_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .operand(operand),
    .exp_res(exp_res), .dp_r0(dp_r0), .dp_check(dp_check), .dp_out(dp_out),
    .dp_out1(dp_out1), .busy(busy), .done(done), .fail_mask(fail_mask),
    .fault(fault), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  fault_scan_seq #(.SETTLE_CYCLES(0), .NUM_CHECKS(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort), .operand(operand),
    .exp_res(exp_res), .dp_r0(dp_r0_2), .dp_check(dp_check_2), .dp_out(dp_out_2),
    .dp_out1(dp_out1_2), .busy(busy2), .done(done2), .fail_mask(fail_mask2),
    .fault(fault2), .rd_idx(rd_idx), .rd_data(rd_data2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [7:0] op, input logic [19:0] ex);
    operand = op;
    exp_res = ex;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
    operand = 8'd0; exp_res = 20'd0; rd_idx = 2'd0;
    tick(); tick();
    checks++;
    if ({dp_r0, dp_check, busy, done, fail_mask, fault, rd_data} !== 22'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {dp_r0, dp_check, busy, done, fail_mask, fault, rd_data});
    end
    checks++;
    if ({dp_r0_2, dp_check_2, busy2, done2, fail_mask2, fault2, rd_data2} !== 22'd0) begin
      fails++;
      $display("FAIL reset_outputs_min: got %h expected 0", {dp_r0_2, dp_check_2, busy2, done2, fail_mask2, fault2, rd_data2});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_scan();
    start_scan(8'hA5, EXP_GOOD);
    checks++;
    if (busy !== 1'b1 || dp_r0 !== 8'hA5) begin
      fails++;
      $display("FAIL clean_accept: got busy=%b r0=%h expected busy=1 r0=a5", busy, dp_r0);
    end
    for (int n = 1; n <= 16; n++) begin
      checks++;
      if (done !== 1'b0 || dp_check !== 2'((n - 1) / 4)) begin
        fails++;
        $display("FAIL clean_step c%0d: got done=%b check=%0d expected done=0 check=%0d", n, done, dp_check, (n - 1) / 4);
      end
      tick();
    end
    checks++;
    if ({done, busy, fail_mask, fault} !== 7'b11_0000_0) begin
      fails++;
      $display("FAIL clean_done: got done=%b busy=%b mask=%b fault=%b expected 1 1 0000 0", done, busy, fail_mask, fault);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clean_after: got done=%b busy=%b expected 0 0", done, busy);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_data !== dp_model(2'(i))) begin
        fails++;
        $display("FAIL clean_readback %0d: got %h expected %h", i, rd_data, dp_model(2'(i)));
      end
    end
  endtask

  task automatic test_fail_mask();
    int n;
    start_scan(8'hA5, EXP_BAD2);
    wait_done(n);
    checks++;
    if (n !== 17) begin fails++; $display("FAIL bad2_latency: got %0d expected 17", n); end
    checks++;
    if (fail_mask !== 4'b0100 || fault !== 1'b1) begin
      fails++;
      $display("FAIL bad2_mask: got mask=%b fault=%b expected 0100 1", fail_mask, fault);
    end
    rd_idx = 2'd2;
    #1;
    checks++;
    if (rd_data !== 5'h04) begin fails++; $display("FAIL bad2_readback: got %h expected 04", rd_data); end
    tick();
    checks++;
    if (fault !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL bad2_fault_held: got fault=%b done=%b expected 1 0", fault, done);
    end
  endtask

  task automatic test_abort_in_idle();
    abort = 1'b1; start = 1'b1; operand = 8'h3C;
    tick();
    abort = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || fault !== 1'b1 || dp_r0 !== 8'hA5) begin
      fails++;
      $display("FAIL idle_abort: got busy=%b fault=%b r0=%h expected 0 1 a5", busy, fault, dp_r0);
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int first = 0;
    start_scan(8'hA5, EXP_GOOD);
    for (int n = 1; n <= 30; n++) begin
      if (done === 1'b1) begin
        dones++;
        if (first == 0) first = n;
      end
      start   = (n == 3 || n == 9);
      operand = start ? 8'h3C : 8'hA5;
      tick();
    end
    start = 1'b0;
    checks++;
    if (dones !== 1 || first !== 17) begin
      fails++;
      $display("FAIL restart_done: got count=%0d at=%0d expected 1 at 17", dones, first);
    end
    checks++;
    if (dp_r0 !== 8'hA5 || fail_mask !== 4'd0) begin
      fails++;
      $display("FAIL restart_operand: got r0=%h mask=%b expected a5 0000", dp_r0, fail_mask);
    end
  endtask

  task automatic test_abort();
    int n;
    int dones = 0;
    start_scan(8'hA5, EXP_BAD0);
    for (int c = 1; c < 6; c++) tick();
    checks++;
    if (fail_mask !== 4'b0001 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: got mask=%b busy=%b expected 0001 1", fail_mask, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, done, fail_mask, fault, dp_check} !== 9'd0) begin
      fails++;
      $display("FAIL abort_idle: got busy=%b done=%b mask=%b fault=%b check=%0d expected all 0", busy, done, fail_mask, fault, dp_check);
    end
    for (int c = 0; c < 25; c++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin fails++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    start_scan(8'hA5, EXP_GOOD);
    wait_done(n);
    checks++;
    if (n !== 17 || fail_mask !== 4'd0) begin
      fails++;
      $display("FAIL abort_rescan: got at=%0d mask=%b expected 17 0000", n, fail_mask);
    end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int dones = 0;
    rd_idx = 2'd0;
    start_scan(8'hA5, EXP_BAD0);
    for (int c = 1; c < 10; c++) tick();
    checks++;
    if (fail_mask !== 4'b0001 || rd_data !== 5'h15) begin
      fails++;
      $display("FAIL rst_pre: got mask=%b rd=%h expected 0001 15", fail_mask, rd_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({dp_r0, dp_check, busy, done, fail_mask, fault, rd_data} !== 22'd0) begin
      fails++;
      $display("FAIL rst_mid: got %h expected 0", {dp_r0, dp_check, busy, done, fail_mask, fault, rd_data});
    end
    for (int c = 0; c < 25; c++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin fails++; $display("FAIL rst_no_done: got %0d expected 0", dones); end
  endtask

  task automatic test_min_config();
    int n;
    rd_idx  = 2'd0;
    exp_res = {15'h7FFF, 5'h00};
    start2  = 1'b1;
    tick();
    start2  = 1'b0;
    n = 1;
    while (done2 !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (n !== 3) begin fails++; $display("FAIL min_latency: got %0d expected 3", n); end
    checks++;
    if (fail_mask2 !== 4'b0001 || fault2 !== 1'b1 || rd_data2 !== 5'h15) begin
      fails++;
      $display("FAIL min_mask: got mask=%b fault=%b rd=%h expected 0001 1 15", fail_mask2, fault2, rd_data2);
    end
    tick();
    checks++;
    if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      fails++;
      $display("FAIL min_after: got done=%b busy=%b expected 0 0", done2, busy2);
    end
    exp_res = {15'h7FFF, 5'h15};
    start2  = 1'b1;
    tick();
    start2  = 1'b0;
    n = 1;
    while (done2 !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (n !== 3 || fail_mask2 !== 4'd0 || fault2 !== 1'b0) begin
      fails++;
      $display("FAIL min_pass: got at=%0d mask=%b fault=%b expected 3 0000 0", n, fail_mask2, fault2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_scan();
    test_fail_mask();
    test_abort_in_idle();
    test_start_ignored();
    test_abort();
    test_reset_mid_scan();
    test_min_config();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
